// File: rtl/u_mem_arb_pkg.sv
// u_mem_arb_pkg: shared state/owner encodings and constants for the memory arbiter.
package u_mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
   typedef enum logic {OWN_IF, OWN_LS} owner_e;
   localparam logic [3:0] IF_RE = 4'b1111;
endpackage

// File: rtl/u_mem_arb_if.sv
// u_mem_arb_if: IF, LS and memory buses of the arbiter; slave is the arbiter's view.
interface u_mem_arb_if;
   logic        if_req, if_flush, if_gnt, if_vld;
   logic [31:0] if_adr, if_rd;
   logic        ls_req, ls_gnt, ls_vld;
   logic [31:0] ls_adr, ls_wd, ls_rd;
   logic [3:0]  ls_we, ls_re;
   logic        mem_req, mem_rdy, mem_vld;
   logic [31:0] mem_adr, mem_wd, mem_rd;
   logic [3:0]  mem_we, mem_re;
   modport slave (
      input  if_req, if_adr, if_flush, ls_req, ls_adr, ls_we, ls_wd, ls_re, mem_rdy, mem_vld, mem_rd,
      output if_gnt, if_vld, if_rd, ls_gnt, ls_vld, ls_rd, mem_req, mem_adr, mem_we, mem_wd, mem_re
   );
   modport master (
      output if_req, if_adr, if_flush, ls_req, ls_adr, ls_we, ls_wd, ls_re, mem_rdy, mem_vld, mem_rd,
      input  if_gnt, if_vld, if_rd, ls_gnt, ls_vld, ls_rd, mem_req, mem_adr, mem_we, mem_wd, mem_re
   );
endinterface

// File: rtl/u_mem_arb.sv
// u_mem_arb: LS-priority single-port memory arbiter with an IF starvation guard.
// Optional U_MEM_ARB_TIMEOUT_EN aborts a transaction after TIMEOUT_CYC cycles in ISSUE/WAIT.
module u_mem_arb
   import u_mem_arb_pkg::*;
#(
   parameter int STARVE_MAX  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rstn,
   u_mem_arb_if.slave bus,
   output logic       busy,
   output logic       err
);
   state_e      state_q;
   owner_e      owner_q;
   logic [3:0]  starve_q, we_q, re_q;
   logic        drop_q;
   logic [31:0] adr_q, wd_q;
   logic        idle, ls_win, if_win, gnt, resp, tmo, tmo_hit, done, kill;
`ifdef U_MEM_ARB_TIMEOUT_EN
   logic [15:0] tmo_q;
   assign tmo = state_q != IDLE && tmo_q == 16'(TIMEOUT_CYC - 1);
`else
   logic unused_tmo;
   assign tmo = 1'b0;
   assign unused_tmo = ^32'(TIMEOUT_CYC);
`endif
   // grants are gated by rstn so every output is 0 while reset is held
   always_comb begin
      idle    = state_q == IDLE;
      ls_win  = rstn && idle && bus.ls_req && !(bus.if_req && starve_q == 4'(STARVE_MAX));
      if_win  = rstn && idle && !ls_win && bus.if_req && !bus.if_flush;
      gnt     = ls_win || if_win;
      resp    = state_q == WAIT && bus.mem_vld;
      tmo_hit = tmo && !resp;
      done    = resp || tmo_hit;
      kill    = owner_q == OWN_IF && (drop_q || bus.if_flush);
      bus.if_gnt  = if_win;
      bus.ls_gnt  = ls_win;
      bus.if_vld  = done && owner_q == OWN_IF && !kill;
      bus.ls_vld  = done && owner_q == OWN_LS;
      bus.if_rd   = bus.if_vld && resp ? bus.mem_rd : 32'h0;
      bus.ls_rd   = bus.ls_vld && resp ? bus.mem_rd : 32'h0;
      bus.mem_req = state_q == ISSUE && !tmo_hit;
      bus.mem_adr = bus.mem_req ? adr_q : 32'h0;
      bus.mem_wd  = bus.mem_req ? wd_q : 32'h0;
      bus.mem_we  = bus.mem_req ? we_q : 4'h0;
      bus.mem_re  = bus.mem_req ? re_q : 4'h0;
      busy = !idle;
      err  = tmo_hit;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q  <= IDLE;
         owner_q  <= OWN_IF;
         starve_q <= '0;
         drop_q   <= 1'b0;
         adr_q    <= '0;
         we_q     <= '0;
         wd_q     <= '0;
         re_q     <= '0;
`ifdef U_MEM_ARB_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else if (gnt) begin
         state_q  <= ISSUE;
         owner_q  <= ls_win ? OWN_LS : OWN_IF;
         adr_q    <= ls_win ? bus.ls_adr : bus.if_adr;
         we_q     <= ls_win ? bus.ls_we : 4'h0;
         wd_q     <= ls_win ? bus.ls_wd : 32'h0;
         re_q     <= ls_win ? bus.ls_re : IF_RE;
         starve_q <= if_win ? 4'd0 : (bus.if_req && starve_q != 4'(STARVE_MAX)) ? starve_q + 4'd1 : starve_q;
         drop_q   <= 1'b0;
`ifdef U_MEM_ARB_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else if (done) begin
         state_q <= IDLE;
         drop_q  <= 1'b0;
      end else begin
         if (state_q == ISSUE && bus.mem_rdy) state_q <= WAIT;
         drop_q <= drop_q || (!idle && owner_q == OWN_IF && bus.if_flush);
`ifdef U_MEM_ARB_TIMEOUT_EN
         tmo_q  <= idle ? tmo_q : tmo_q + 16'd1;
`endif
      end
endmodule

// File: doc/u_mem_arb.md
Name: u_mem_arb

Overview:
Single-port memory arbiter sharing one 32-bit memory between the instruction fetch unit (IF) and the execute-stage load/store unit (LS). Sits between the ifu/u_exe lsu interfaces and the memory. At most one transaction is outstanding. LS has priority, with a starvation counter that guarantees IF progress.

Parameters:
STARVE_MAX, 4, consecutive LS grants allowed while if_req is pending before IF is forced to win (1..15)
TIMEOUT_CYC, 64, cycles in ISSUE+WAIT before abort (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_adr until if_gnt
if_adr  in  32  fetch word address
if_flush  in  1  fetch redirected; discard pending or granted fetch
if_gnt  out  1  fetch accepted this cycle
if_vld  out  1  fetch data valid (1 cycle)
if_rd  out  32  fetch data
ls_req  in  1  load/store request; held with ls_* until ls_gnt
ls_adr  in  32  data address
ls_we  in  4  byte write enables
ls_wd  in  32  write data
ls_re  in  4  byte read enables
ls_gnt  out  1  LS accepted this cycle
ls_vld  out  1  LS completion/read data valid (1 cycle)
ls_rd  out  32  read data
mem_req  out  1  memory request
mem_adr  out  32  memory address
mem_we  out  4  memory byte write enables
mem_wd  out  32  memory write data
mem_re  out  4  memory byte read enables
mem_rdy  in  1  memory accepts mem_req this cycle
mem_vld  in  1  memory response (returned for reads and writes)
mem_rd  in  32  memory read data
busy  out  1  state != IDLE
err  out  1  timeout pulse (tied 0 without the optional feature)

Behaviour:
- Clock/reset: one clock clk; rstn asynchronous active-low. On reset: state=IDLE; owner=IF; starve_cnt=0; drop=0; all outputs 0.
- State IDLE: the arbiter picks a winner combinationally.
  - LS wins if ls_req && !(if_req && starve_cnt==STARVE_MAX).
  - Otherwise IF wins if if_req && !if_flush.
  - The winner's gnt is high in the same cycle. Address, we, wd and re are latched (IF: we=0, re=4'b1111). Next state is ISSUE.
  - No request: stay in IDLE.
- State ISSUE: mem_req=1 with the latched fields, held stable until mem_rdy. When mem_rdy is sampled high, go to WAIT.
- State WAIT: mem_req=0. When mem_vld is high:
  - owner's vld=1 and rd=mem_rd (combinational pass-through), unless owner==IF && drop.
  - Next state is IDLE.
- mem_rdy and mem_vld are ignored in IDLE. mem_vld is ignored in ISSUE.
- Minimum latency: req at cycle 0 (gnt at 0); mem_req at 1; mem_rdy at 1 gives mem_vld at 2 and vld at 2; next grant at 3.
- if_vld, if_rd, ls_vld, ls_rd are 0 whenever not asserting a response.
- Starvation counter:
  - LS granted while if_req high: starve_cnt increments, saturating at STARVE_MAX.
  - IF granted: starve_cnt clears to 0.
  - LS granted with if_req low: starve_cnt unchanged.
- Flush:
  - if_flush while owner==IF in ISSUE or WAIT sets drop. The memory transaction still completes; if_vld is suppressed.
  - drop clears on entering IDLE.
  - if_flush in IDLE blocks the IF grant that cycle; LS is still grantable.
- ls_gnt and if_gnt are never high in the same cycle. gnt is only high in IDLE.

Optional Feature:
U_MEM_ARB_TIMEOUT_EN
- Defined: a counter clears on leaving IDLE and increments each cycle in ISSUE/WAIT. When it reaches TIMEOUT_CYC:
  - force IDLE;
  - err=1 for one cycle;
  - owner's vld=1 with rd=32'h0 (suppressed if drop);
  - mem_req drops.
  - A late mem_vld is then ignored, since it arrives in IDLE.
- Undefined: no counter; err tied 0; the arbiter waits indefinitely.

Decomposition:
- Package u_mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT} (2-bit);
  - owner enum {OWN_IF, OWN_LS};
  - constant IF_RE=4'b1111.
- No sub-module: arbitration, FSM and counters stay in u_mem_arb.

Test Plan:
- Basic fetch: if_req, if_adr=0x100; mem_rdy at once; mem_vld next cycle with mem_rd=0x00000013 -> if_gnt cycle 0; mem_adr=0x100, mem_re=4'hF at cycle 1; if_vld with if_rd=0x13 at cycle 2; busy 1..2.
- Simultaneous requests: if_req+ls_req, ls_adr=0x2000, ls_we=4'hF, ls_wd=0xCAFEBABE -> ls_gnt first; mem_we=4'hF; ls_vld at mem_vld; if_gnt at the following IDLE.
- Starvation: ls_req and if_req held high continuously, STARVE_MAX=4 -> exactly 4 ls_gnt, then if_gnt, then the counter resets and LS wins again.
- Flush: IF granted, mem_rdy delayed 3 cycles, if_flush pulsed in ISSUE -> transaction completes; if_vld stays 0; the next IF grant is accepted normally.
- Reset mid-operation: rstn low during WAIT -> all outputs 0 immediately; after release, a stale mem_vld is ignored and busy=0.
- Timeout (U_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): LS read, mem_rdy=1, no mem_vld -> at cycle 8 after leaving IDLE, err=1 for one cycle, ls_vld=1 with ls_rd=0, state IDLE.
